// File: rtl/bsg_wormhole_link_arbiter.sv
// Packet-atomic round-robin arbiter that merges num_in_p wormhole links onto one ready/valid link.
// Optional BSG_WH_ARB_PKT_CNT_EN adds a 16-bit completed-packet counter on pkt_cnt_o.
module bsg_wormhole_link_arbiter #(
  parameter int num_in_p     = 2,
  parameter int width_p      = 64,
  parameter int len_width_p  = 4,
  parameter int len_offset_p = 0
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [num_in_p-1:0]          v_i,
  input  logic [num_in_p*width_p-1:0]  data_i,
  output logic [num_in_p-1:0]          ready_and_o,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         ready_and_i,
  output logic [num_in_p-1:0]          grant_o
`ifdef BSG_WH_ARB_PKT_CNT_EN
  ,
  output logic [15:0]                  pkt_cnt_o
`endif
);

  localparam int sel_width_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                  state_q, state_d;
  logic [sel_width_lp-1:0] last_q, last_d;
  logic [sel_width_lp-1:0] owner_q, owner_d;
  logic [len_width_p-1:0]  cnt_q, cnt_d;

  logic [sel_width_lp-1:0] sel;
  logic [sel_width_lp:0]   cand;
  logic [sel_width_lp-1:0] cand_sel;
  logic                    sel_found;
  logic [len_width_p-1:0]  hdr_len;
  logic [width_p-1:0]      in_data [num_in_p];

  genvar gi;
  generate
    for (gi = 0; gi < num_in_p; gi++) begin : g_split
      assign in_data[gi] = data_i[gi*width_p +: width_p];
    end
  endgenerate

  // Search upward from the input after the last winner; cand carries one extra bit so the wrap is a single subtract.
  always_comb begin
    sel       = last_q;
    sel_found = 1'b0;
    cand      = '0;
    cand_sel  = '0;
    for (int i = 0; i < num_in_p; i++) begin
      cand = {1'b0, last_q} + (sel_width_lp+1)'(i + 1);
      if (cand >= (sel_width_lp+1)'(num_in_p)) begin
        cand = cand - (sel_width_lp+1)'(num_in_p);
      end
      cand_sel = cand[sel_width_lp-1:0];
      if (!sel_found && v_i[cand_sel]) begin
        sel       = cand_sel;
        sel_found = 1'b1;
      end
    end
  end

  assign hdr_len = in_data[sel][len_offset_p +: len_width_p];

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    v_o         = 1'b0;
    data_o      = in_data[sel];
    ready_and_o = '0;
    grant_o     = '0;

    if (state_q == IDLE) begin
      if (sel_found) begin
        grant_o[sel]     = 1'b1;
        v_o              = 1'b1;
        ready_and_o[sel] = ready_and_i;
        if (ready_and_i) begin
          last_d = sel;
          if (hdr_len != '0) begin
            state_d = BUSY;
            owner_d = sel;
            cnt_d   = hdr_len;
          end
        end
      end
    end else begin
      grant_o[owner_q]     = 1'b1;
      v_o                  = v_i[owner_q];
      data_o               = in_data[owner_q];
      ready_and_o[owner_q] = ready_and_i;
      if (v_i[owner_q] && ready_and_i) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == len_width_p'(1)) begin
          state_d = IDLE;
        end
      end
    end

    // Outputs stay quiet for the whole time reset is held, not just until the flops clear.
    if (reset_i) begin
      v_o         = 1'b0;
      ready_and_o = '0;
      grant_o     = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      last_q  <= sel_width_lp'(num_in_p - 1);
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BSG_WH_ARB_PKT_CNT_EN
  logic        pkt_done;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  assign pkt_done  = v_o && ready_and_i &&
                     (((state_q == IDLE) && (hdr_len == '0)) ||
                      ((state_q == BUSY) && (cnt_q == len_width_p'(1))));
  assign pkt_cnt_d = pkt_done ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
  assign pkt_cnt_o = reset_i ? 16'd0 : pkt_cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end
`endif

endmodule
